// File: rtl/ifetch_queue.sv
`timescale 1ns/1ps
// Instruction fetch queue: fetches words over a req/ack port, predecodes them and buffers
// {pc, inst, type, format} in a DEPTH-entry FIFO. Define IFQ_BYPASS_EN for empty-FIFO bypass.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_req,
  output logic [ADDR_W-3:0]            mem_addr_I,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata_I,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [31:0]                  out_inst,
  output logic [22:0]                  out_type,
  output logic [4:0]                   out_format,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  // Handshakes: a memory request completes on the cycle mem_req && mem_ack; the address is
  // held while mem_req=1. The head entry transfers on the cycle out_valid && out_ready.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic              fifo_empty, ack_live, bypass, push, pop;
  logic [6:0]        op;
  logic [2:0]        f3;
  logic              f7_nz;
  logic [22:0]       dec_type;
  logic [4:0]        dec_fmt;
  logic              unused_pc_lsbs;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [22:0]       type_mem [DEPTH];
  logic [4:0]        fmt_mem  [DEPTH];

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    op       = mem_rdata_I[6:0];
    f3       = mem_rdata_I[14:12];
    f7_nz    = |mem_rdata_I[31:25];
    dec_type = '0;
    dec_fmt  = '0;
    case (op)
      7'h6f: begin dec_fmt = 5'b00001; dec_type[22] = 1'b1; end
      7'h63: begin
        dec_fmt = 5'b00010;
        if (f3 == 3'd0) dec_type[20] = 1'b1;
        else            dec_type[19] = 1'b1;
      end
      7'h23: begin dec_fmt = 5'b00100; dec_type[17] = 1'b1; end
      7'h33: begin
        dec_fmt = 5'b10000;
        case (f3)
          3'd0: if (f7_nz) dec_type[7] = 1'b1; else dec_type[8] = 1'b1;
          3'd1: dec_type[6] = 1'b1;
          3'd2: dec_type[5] = 1'b1;
          3'd4: dec_type[4] = 1'b1;
          3'd5: if (f7_nz) dec_type[2] = 1'b1; else dec_type[3] = 1'b1;
          3'd6: dec_type[1] = 1'b1;
          3'd7: dec_type[0] = 1'b1;
          default: ;
        endcase
      end
      default: begin
        dec_fmt = 5'b01000;
        if (op == 7'h67)      dec_type[21] = 1'b1;
        else if (op == 7'h03) dec_type[18] = 1'b1;
        else begin
          case (f3)
            3'd0: dec_type[16] = 1'b1;
            3'd1: dec_type[11] = 1'b1;
            3'd2: dec_type[15] = 1'b1;
            3'd4: dec_type[14] = 1'b1;
            3'd5: if (f7_nz) dec_type[9] = 1'b1; else dec_type[10] = 1'b1;
            3'd6: dec_type[13] = 1'b1;
            3'd7: dec_type[12] = 1'b1;
            default: ;
          endcase
        end
      end
    endcase
  end

  assign fifo_empty = (count == '0);
  assign ack_live   = (state == REQ) && mem_ack && !redirect_valid;
`ifdef IFQ_BYPASS_EN
  assign bypass     = fifo_empty && ack_live;
`else
  assign bypass     = 1'b0;
`endif
  // A bypassed word taken by the consumer in the same cycle never occupies a slot.
  assign push       = ack_live && !(bypass && out_ready);
  assign pop        = !redirect_valid && !fifo_empty && out_ready;
  assign count_next = count + CW'(push) - CW'(pop);
  assign pc_next    = pc_q + ADDR_W'(4);
  assign occupancy  = count;

  always_comb begin
    out_valid  = 1'b0;
    out_pc     = '0;
    out_inst   = '0;
    out_type   = '0;
    out_format = '0;
    if (!fifo_empty) begin
      out_valid  = 1'b1;
      out_pc     = pc_mem[rd_ptr];
      out_inst   = inst_mem[rd_ptr];
      out_type   = type_mem[rd_ptr];
      out_format = fmt_mem[rd_ptr];
    end else if (bypass) begin
      out_valid  = 1'b1;
      out_pc     = pc_q;
      out_inst   = mem_rdata_I;
      out_type   = dec_type;
      out_format = dec_fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr_I <= RESET_PC[ADDR_W-1:2];
    end else if (redirect_valid) begin
      pc_q    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      mem_req <= 1'b1;
      // An unanswered request keeps its address; its data is thrown away in DROP.
      if (state != IDLE && !mem_ack) begin
        state <= DROP;
      end else begin
        state      <= REQ;
        mem_addr_I <= redirect_pc[ADDR_W-1:2];
      end
    end else begin
      case (state)
        IDLE: if (count < CW'(DEPTH)) begin
          state      <= REQ;
          mem_req    <= 1'b1;
          mem_addr_I <= pc_q[ADDR_W-1:2];
        end
        REQ: if (mem_ack) begin
          pc_q <= pc_next;
          if (count_next < CW'(DEPTH)) begin
            mem_addr_I <= pc_next[ADDR_W-1:2];
          end else begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        DROP: if (mem_ack) begin
          state      <= REQ;
          mem_addr_I <= pc_q[ADDR_W-1:2];
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc_q;
      inst_mem[wr_ptr] <= mem_rdata_I;
      type_mem[wr_ptr] <= dec_type;
      fmt_mem[wr_ptr]  <= dec_fmt;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps
// Bench for ifetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_ifetch_queue;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);
  localparam int EW     = ADDR_W + 32 + 23 + 5;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif
  localparam int R_TAB [8] = '{8, 6, 5, -1, 4, 3, 1, 0};
  localparam int I_TAB [8] = '{16, 11, 15, -1, 14, 10, 13, 12};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic [ADDR_W-3:0] mem_addr_I;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata_I = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_inst;
  logic [22:0]       out_type;
  logic [4:0]        out_format;
  logic [CW-1:0]     occupancy;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_img [64];

  // Reference model state
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_pc;
  logic          m_pending;
  logic          m_discard;
  logic [29:0]   m_addr;

  ifetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr_I(mem_addr_I), .mem_ack(mem_ack),
    .mem_rdata_I(mem_rdata_I), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_type(out_type), .out_format(out_format), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [27:0] ref_decode(input logic [31:0] w);
    int f3 = int'(w[14:12]);
    bit alt = (w[31:25] != 7'd0);
    int tb;
    logic [4:0] fm;
    if (w[6:0] == 7'h6f) begin fm = 5'b00001; tb = 22; end
    else if (w[6:0] == 7'h63) begin fm = 5'b00010; tb = (f3 == 0) ? 20 : 19; end
    else if (w[6:0] == 7'h23) begin fm = 5'b00100; tb = 17; end
    else if (w[6:0] == 7'h33) begin
      fm = 5'b10000;
      tb = R_TAB[f3];
      if (alt && f3 == 0) tb = 7;
      if (alt && f3 == 5) tb = 2;
    end else begin
      fm = 5'b01000;
      if (w[6:0] == 7'h67) tb = 21;
      else if (w[6:0] == 7'h03) tb = 18;
      else begin
        tb = I_TAB[f3];
        if (alt && f3 == 5) tb = 9;
      end
    end
    return {(tb < 0) ? 23'd0 : (23'd1 << tb), fm};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [7] = '{7'h6f, 7'h63, 7'h23, 7'h33, 7'h67, 7'h03, 7'h13};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 7);
    if (k < 7) w[6:0] = ops[k];
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Model: one outstanding request, optionally marked for discard; FIFO as a queue.
  always @(posedge clk) begin : model
    int sz;
    logic take;
    if (rst) begin
      exp_q.delete();
      m_pc = RESET_PC; m_pending = 1'b0; m_discard = 1'b0; m_addr = RESET_PC[31:2];
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_pending && !mem_ack) m_discard = 1'b1;
      else begin m_pending = 1'b1; m_discard = 1'b0; m_addr = m_pc[31:2]; end
    end else begin
      sz = exp_q.size();
      take = 1'b0;
`ifdef IFQ_BYPASS_EN
      take = (sz == 0) && m_pending && !m_discard && mem_ack && out_ready;
`endif
      if (out_ready && sz > 0) void'(exp_q.pop_front());
      if (m_pending && mem_ack) begin
        if (m_discard) begin m_discard = 1'b0; m_addr = m_pc[31:2]; end
        else begin
          if (!take) exp_q.push_back({m_pc, mem_rdata_I, ref_decode(mem_rdata_I)});
          m_pc = m_pc + 32'd4;
          if (exp_q.size() < DEPTH) m_addr = m_pc[31:2];
          else m_pending = 1'b0;
        end
      end else if (!m_pending && sz < DEPTH) begin
        m_pending = 1'b1; m_addr = m_pc[31:2];
      end
    end
  end

  task automatic fill_mem();
    foreach (mem_img[i]) mem_img[i] = 32'h00000013;
  endtask

  task automatic drive_mem();
    mem_rdata_I = mem_img[mem_addr_I[5:0]];
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; out_ready = 1'b1; mem_rdata_I = 32'h0000006f;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_addr_I !== 30'(RESET_PC >> 2)) begin errors++; $display("FAIL reset_addr got=%0h exp=%0h", mem_addr_I, RESET_PC >> 2); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if ({out_pc, out_inst, out_type, out_format} !== '0) begin errors++; $display("FAIL reset_out_fields got=%0h/%0h/%0h/%0h exp=0", out_pc, out_inst, out_type, out_format); end
    rst = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode_stream();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [22:0] exp_ty [3] = '{23'h000100, 23'h000080, 23'h400000};
    logic [4:0]  exp_fm [3] = '{5'b10000, 5'b10000, 5'b00001};
    logic [31:0] got_pc [3];
    logic [22:0] got_ty [3];
    logic [4:0]  got_fm [3];
    int n = 0;
    int first_ack = -1;
    int first_valid = -1;
    do_reset();
    fill_mem();
    mem_img[0] = 32'h00000033; mem_img[1] = 32'h40000033; mem_img[2] = 32'h0000006f;
    mem_ack = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      drive_mem(); #1;
      if (mem_req && first_ack < 0) first_ack = c;
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid) begin got_pc[n] = out_pc; got_ty[n] = out_type; got_fm[n] = out_format; n++; end
      @(negedge clk);
    end
    mem_ack = 1'b0; out_ready = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d] got=%0h exp=%0h", i, got_pc[i], exp_pc[i]); end
      checks++; if (got_ty[i] !== exp_ty[i]) begin errors++; $display("FAIL stream_type[%0d] got=%0h exp=%0h", i, got_ty[i], exp_ty[i]); end
      checks++; if (got_fm[i] !== exp_fm[i]) begin errors++; $display("FAIL stream_fmt[%0d] got=%b exp=%b", i, got_fm[i], exp_fm[i]); end
    end
    checks++; if (first_valid - first_ack !== EXP_LAT) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", first_valid - first_ack, EXP_LAT); end
  endtask

  task automatic test_full_backpressure();
    int c = 0;
    do_reset();
    fill_mem();
    mem_ack = 1'b1; out_ready = 1'b0;
    while (occupancy !== CW'(DEPTH) && c < 30) begin drive_mem(); @(negedge clk); c++; end
    #1;
    checks++; if (occupancy !== CW'(DEPTH)) begin errors++; $display("FAIL full_occupancy got=%0d exp=%0d", occupancy, DEPTH); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_mem_req got=%0h exp=0", mem_req); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got=%0h exp=0", out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; mem_ack = 1'b0; #1;
    checks++; if (occupancy !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_pop_occupancy got=%0d exp=%0d", occupancy, DEPTH - 1); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL full_rereq got=%0h exp=1", mem_req); end
    checks++; if (mem_addr_I !== 30'h4) begin errors++; $display("FAIL full_rereq_addr got=%0h exp=4", mem_addr_I); end
  endtask

  task automatic test_redirect_drop();
    int c = 0;
    do_reset();
    mem_ack = 1'b0; out_ready = 1'b0;
    while (mem_req !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_req_start got=%0h exp=1", mem_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h00000103;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr_I !== 30'h0) begin errors++; $display("FAIL drop_hold got=%0h/%0h exp=1/0", mem_req, mem_addr_I); end
    @(negedge clk); #1;
    checks++; if (mem_addr_I !== 30'h0) begin errors++; $display("FAIL drop_hold2 got=%0h exp=0", mem_addr_I); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata_I = 32'h00000063;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got=%0d/%0h exp=0/0", occupancy, out_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr_I !== 30'h40) begin errors++; $display("FAIL drop_next_addr got=%0h/%0h exp=1/40", mem_req, mem_addr_I); end
    mem_ack = 1'b1; mem_rdata_I = 32'h00000013;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h13) begin errors++; $display("FAIL drop_refetch got=%0h/%0h/%0h exp=1/100/13", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_redirect_with_ack();
    int c = 0;
    do_reset();
    fill_mem();
    mem_ack = 1'b1; out_ready = 1'b0;
    while (occupancy !== CW'(2) && c < 20) begin drive_mem(); @(negedge clk); c++; end
    #1;
    checks++; if (occupancy !== CW'(2) || mem_req !== 1'b1) begin errors++; $display("FAIL rdack_setup got=%0d/%0h exp=2/1", occupancy, mem_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h00000200; mem_rdata_I = 32'hdead0013;
    @(negedge clk);
    redirect_valid = 1'b0; mem_ack = 1'b0; #1;
    checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL rdack_flush got=%0d/%0h exp=0/0", occupancy, out_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr_I !== 30'h80) begin errors++; $display("FAIL rdack_addr got=%0h/%0h exp=1/80", mem_req, mem_addr_I); end
    mem_ack = 1'b1; mem_rdata_I = 32'h00000033;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    checks++; if (out_pc !== 32'h200 || out_inst !== 32'h33 || occupancy !== CW'(1)) begin errors++; $display("FAIL rdack_refetch got=%0h/%0h/%0d exp=200/33/1", out_pc, out_inst, occupancy); end
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    fill_mem();
    mem_ack = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin drive_mem(); @(negedge clk); end
    mem_ack = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr_I === 30'(RESET_PC >> 2)) begin errors++; $display("FAIL rstmid_setup got=%0h/%0h exp=1/advanced", mem_req, mem_addr_I); end
    rst = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || mem_addr_I !== 30'(RESET_PC >> 2) || occupancy !== '0) begin errors++; $display("FAIL rstmid_state got=%0h/%0h/%0d exp=0/%0h/0", mem_req, mem_addr_I, occupancy, RESET_PC >> 2); end
    @(negedge clk);
    mem_ack = 1'b0; #1;
    checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stray_ack got=%0d/%0h exp=0/0", occupancy, out_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr_I !== 30'(RESET_PC >> 2)) begin errors++; $display("FAIL rstmid_restart got=%0h/%0h exp=1/%0h", mem_req, mem_addr_I, RESET_PC >> 2); end
    out_ready = 1'b0;
  endtask

  task automatic test_decode_shift();
    logic [22:0] got_ty [2];
    logic [4:0]  got_fm [2];
    int n = 0;
    do_reset();
    fill_mem();
    mem_img[0] = 32'h00005013; mem_img[1] = 32'h40005013;
    mem_ack = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 30 && n < 2; c++) begin
      drive_mem(); #1;
      if (out_valid) begin got_ty[n] = out_type; got_fm[n] = out_format; n++; end
      @(negedge clk);
    end
    mem_ack = 1'b0; out_ready = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL shift_count got=%0d exp=2", n); end
    checks++; if (got_ty[0] !== 23'h400 || got_fm[0] !== 5'b01000) begin errors++; $display("FAIL shift_srli got=%0h/%b exp=400/01000", got_ty[0], got_fm[0]); end
    checks++; if (got_ty[1] !== 23'h200 || got_fm[1] !== 5'b01000) begin errors++; $display("FAIL shift_srai got=%0h/%b exp=200/01000", got_ty[1], got_fm[1]); end
  endtask

  task automatic test_random();
    logic          e_valid;
    logic [31:0]   e_pc, e_inst;
    logic [22:0]   e_type;
    logic [4:0]    e_fmt;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      mem_ack        = ($urandom_range(0, 99) < 55);
      out_ready      = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom;
      mem_rdata_I    = rand_inst();
      #1;
      e_valid = 1'b0; e_pc = '0; e_inst = '0; e_type = '0; e_fmt = '0;
      if (exp_q.size() > 0) begin
        e_valid = 1'b1;
        {e_pc, e_inst, e_type, e_fmt} = exp_q[0];
      end
`ifdef IFQ_BYPASS_EN
      else if (m_pending && !m_discard && mem_ack && !redirect_valid) begin
        e_valid = 1'b1; e_pc = m_pc; e_inst = mem_rdata_I;
        {e_type, e_fmt} = ref_decode(mem_rdata_I);
      end
`endif
      checks++; if (mem_req !== m_pending) begin errors++; $display("FAIL rnd_mem_req c=%0d got=%0h exp=%0h", c, mem_req, m_pending); end
      if (m_pending) begin
        checks++; if (mem_addr_I !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, mem_addr_I, m_addr); end
      end
      checks++; if (occupancy !== CW'(exp_q.size())) begin errors++; $display("FAIL rnd_occupancy c=%0d got=%0d exp=%0d", c, occupancy, exp_q.size()); end
      checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%0h exp=%0h", c, out_valid, e_valid); end
      checks++; if (out_pc !== e_pc) begin errors++; $display("FAIL rnd_out_pc c=%0d got=%0h exp=%0h", c, out_pc, e_pc); end
      checks++; if (out_inst !== e_inst) begin errors++; $display("FAIL rnd_out_inst c=%0d got=%0h exp=%0h", c, out_inst, e_inst); end
      checks++; if (out_type !== e_type) begin errors++; $display("FAIL rnd_out_type c=%0d got=%0h exp=%0h", c, out_type, e_type); end
      checks++; if (out_format !== e_fmt) begin errors++; $display("FAIL rnd_out_format c=%0d got=%b exp=%b", c, out_format, e_fmt); end
      @(negedge clk);
    end
    rst = 1'b0; mem_ack = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_decode_stream();
    test_full_backpressure();
    test_redirect_drop();
    test_redirect_with_ack();
    test_reset_mid_request();
    test_decode_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
